// File: rtl/dispatch_stage_pkg.sv
// Shared widths and the buffered uop record for the dispatch stage.
// The busy table uses the helper to qualify writeback hits on a register index.
package dispatch_stage_pkg;

  localparam int PREG_W    = 6;
  localparam int PREG_NUM  = 2 ** PREG_W;
  localparam int ROB_W     = 5;
  localparam int PAYLOAD_W = 192;

  typedef struct packed {
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [PREG_W-1:0]    prd;
    logic                 src1_is_reg;
    logic                 src2_is_reg;
    logic                 need_to_wb;
    logic                 robidx_flag;
    logic [ROB_W-1:0]     robidx;
    logic [PAYLOAD_W-1:0] payload;
  } uop_t;

  function automatic logic idx_hit(input logic valid,
                                   input logic [PREG_W-1:0] a,
                                   input logic [PREG_W-1:0] b);
    return valid & (a == b);
  endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Physical-register busy bits with two clear ports, one set port and two
// read ports that see same-cycle clears; register 0 never reads busy.
module dispatch_stage_busy_table
  import dispatch_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr0_valid,
  input  logic [PREG_W-1:0] clr0_idx,
  input  logic              clr1_valid,
  input  logic [PREG_W-1:0] clr1_idx,
  input  logic              set_valid,
  input  logic [PREG_W-1:0] set_idx,
  input  logic [PREG_W-1:0] rd0_idx,
  input  logic [PREG_W-1:0] rd1_idx,
  output logic              rd0_busy,
  output logic              rd1_busy
);

  logic [PREG_NUM-1:0] busy_q;
  logic [PREG_NUM-1:0] busy_d;

  // The set is applied last so it wins over a clear of the same register.
  always_comb begin
    busy_d = busy_q;
    if (clr0_valid) busy_d[clr0_idx] = 1'b0;
    if (clr1_valid) busy_d[clr1_idx] = 1'b0;
    if (set_valid)  busy_d[set_idx]  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign rd0_busy = (rd0_idx != '0) & busy_q[rd0_idx]
                  & ~idx_hit(clr0_valid, clr0_idx, rd0_idx)
                  & ~idx_hit(clr1_valid, clr1_idx, rd0_idx);
  assign rd1_busy = (rd1_idx != '0) & busy_q[rd1_idx]
                  & ~idx_hit(clr0_valid, clr0_idx, rd1_idx)
                  & ~idx_hit(clr1_valid, clr1_idx, rd1_idx);

endmodule

// File: rtl/dispatch_stage.sv
// Two-entry in-order buffer between rename and the integer issue queue; it also
// tracks which physical registers are still awaiting writeback.
module dispatch_stage
  import dispatch_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rn_valid,
  output logic                 rn_ready,
  input  logic [PREG_W-1:0]    rn_prs1,
  input  logic [PREG_W-1:0]    rn_prs2,
  input  logic [PREG_W-1:0]    rn_prd,
  input  logic                 rn_src1_is_reg,
  input  logic                 rn_src2_is_reg,
  input  logic                 rn_need_to_wb,
  input  logic                 rn_robidx_flag,
  input  logic [ROB_W-1:0]     rn_robidx,
  input  logic [PAYLOAD_W-1:0] rn_payload,
  output logic                 enq_valid,
  input  logic                 enq_ready,
  output logic [PREG_W-1:0]    enq_prs1,
  output logic [PREG_W-1:0]    enq_prs2,
  output logic [PREG_W-1:0]    enq_prd,
  output logic                 enq_src1_is_reg,
  output logic                 enq_src2_is_reg,
  output logic                 enq_need_to_wb,
  output logic                 enq_robidx_flag,
  output logic [ROB_W-1:0]     enq_robidx,
  output logic [PAYLOAD_W-1:0] enq_payload,
  output logic                 enq_src1_state,
  output logic                 enq_src2_state,
  input  logic                 writeback0_valid,
  input  logic                 writeback0_need_to_wb,
  input  logic [PREG_W-1:0]    writeback0_prd,
  input  logic                 writeback1_valid,
  input  logic                 writeback1_need_to_wb,
  input  logic [PREG_W-1:0]    writeback1_prd,
  input  logic                 flush_valid
);

  uop_t       mem_q [2];
  uop_t       mem_d [2];
  uop_t       rn_uop;
  uop_t       head;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic       empty, full, push, pop;
  logic       src1_busy, src2_busy;

  always_comb begin
    rn_uop             = '0;
    rn_uop.prs1        = rn_prs1;
    rn_uop.prs2        = rn_prs2;
    rn_uop.prd         = rn_prd;
    rn_uop.src1_is_reg = rn_src1_is_reg;
    rn_uop.src2_is_reg = rn_src2_is_reg;
    rn_uop.need_to_wb  = rn_need_to_wb;
    rn_uop.robidx_flag = rn_robidx_flag;
    rn_uop.robidx      = rn_robidx;
    rn_uop.payload     = rn_payload;
  end

  // Pointer bit 1 is the wrap flag distinguishing full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[0] == rd_ptr_q[0]) & (wr_ptr_q[1] != rd_ptr_q[1]);
  assign rn_ready  = ~full & ~flush_valid;
  assign enq_valid = ~empty & ~flush_valid;
  assign push      = rn_valid & rn_ready;
  assign pop       = enq_valid & enq_ready;
  assign head      = mem_q[rd_ptr_q[0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_valid) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[0]] = rn_uop;
        wr_ptr_d           = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign enq_prs1        = head.prs1;
  assign enq_prs2        = head.prs2;
  assign enq_prd         = head.prd;
  assign enq_src1_is_reg = head.src1_is_reg;
  assign enq_src2_is_reg = head.src2_is_reg;
  assign enq_need_to_wb  = head.need_to_wb;
  assign enq_robidx_flag = head.robidx_flag;
  assign enq_robidx      = head.robidx;
  assign enq_payload     = head.payload;

  dispatch_stage_busy_table u_busy_table (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr0_valid (writeback0_valid & writeback0_need_to_wb),
    .clr0_idx   (writeback0_prd),
    .clr1_valid (writeback1_valid & writeback1_need_to_wb),
    .clr1_idx   (writeback1_prd),
    .set_valid  (pop & head.need_to_wb & (head.prd != '0)),
    .set_idx    (head.prd),
    .rd0_idx    (head.prs1),
    .rd1_idx    (head.prs2),
    .rd0_busy   (src1_busy),
    .rd1_busy   (src2_busy)
  );

  assign enq_src1_state = head.src1_is_reg & src1_busy;
  assign enq_src2_state = head.src2_is_reg & src2_busy;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: buffering, ordering, flush, reset and
// busy-table behaviour with hand-computed expectations.
module tb_dispatch_stage;
  import dispatch_stage_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 rn_valid, rn_ready;
  logic [PREG_W-1:0]    rn_prs1, rn_prs2, rn_prd;
  logic                 rn_src1_is_reg, rn_src2_is_reg, rn_need_to_wb;
  logic                 rn_robidx_flag;
  logic [ROB_W-1:0]     rn_robidx;
  logic [PAYLOAD_W-1:0] rn_payload;
  logic                 enq_valid, enq_ready;
  logic [PREG_W-1:0]    enq_prs1, enq_prs2, enq_prd;
  logic                 enq_src1_is_reg, enq_src2_is_reg, enq_need_to_wb;
  logic                 enq_robidx_flag;
  logic [ROB_W-1:0]     enq_robidx;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic                 enq_src1_state, enq_src2_state;
  logic                 writeback0_valid, writeback0_need_to_wb;
  logic [PREG_W-1:0]    writeback0_prd;
  logic                 writeback1_valid, writeback1_need_to_wb;
  logic [PREG_W-1:0]    writeback1_prd;
  logic                 flush_valid;

  int check_count = 0;
  int error_count = 0;

  always #5 clock = ~clock;

  dispatch_stage dut (
    .clock(clock), .reset_n(reset_n),
    .rn_valid(rn_valid), .rn_ready(rn_ready),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_prd(rn_prd),
    .rn_src1_is_reg(rn_src1_is_reg), .rn_src2_is_reg(rn_src2_is_reg),
    .rn_need_to_wb(rn_need_to_wb), .rn_robidx_flag(rn_robidx_flag),
    .rn_robidx(rn_robidx), .rn_payload(rn_payload),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2), .enq_prd(enq_prd),
    .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
    .enq_need_to_wb(enq_need_to_wb), .enq_robidx_flag(enq_robidx_flag),
    .enq_robidx(enq_robidx), .enq_payload(enq_payload),
    .enq_src1_state(enq_src1_state), .enq_src2_state(enq_src2_state),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd),
    .flush_valid(flush_valid)
  );

  function automatic logic [PAYLOAD_W-1:0] payload_of(input logic [ROB_W-1:0] rob);
    return {{(PAYLOAD_W-32){1'b0}}, 32'hCAFE_0000 | 32'(rob)} ^ {32'h5A5A_A5A5, {(PAYLOAD_W-32){1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_output(input string tag, input logic [PAYLOAD_W-1:0] observed,
                              input logic [PAYLOAD_W-1:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] prs1,
                                input logic [PREG_W-1:0] prs2, input logic [PREG_W-1:0] prd,
                                input logic s1_reg, input logic s2_reg, input logic nwb,
                                input logic flag);
    rn_valid       = 1'b1;
    rn_robidx      = rob;
    rn_prs1        = prs1;
    rn_prs2        = prs2;
    rn_prd         = prd;
    rn_src1_is_reg = s1_reg;
    rn_src2_is_reg = s2_reg;
    rn_need_to_wb  = nwb;
    rn_robidx_flag = flag;
    rn_payload     = payload_of(rob);
  endtask

  initial begin
    reset_n = 1'b0; rn_valid = 1'b0; enq_ready = 1'b1; flush_valid = 1'b0;
    rn_prs1 = '0; rn_prs2 = '0; rn_prd = '0; rn_robidx = '0; rn_payload = '0;
    rn_src1_is_reg = 1'b0; rn_src2_is_reg = 1'b0; rn_need_to_wb = 1'b0; rn_robidx_flag = 1'b0;
    writeback0_valid = 1'b0; writeback0_need_to_wb = 1'b0; writeback0_prd = '0;
    writeback1_valid = 1'b0; writeback1_need_to_wb = 1'b0; writeback1_prd = '0;

    // Reset held with a uop waiting on rename.
    apply_stimulus(5'd1, 6'd0, 6'd0, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick(); settle();
    check_output("rst_enq_valid", enq_valid, 0);
    check_output("rst_rn_ready", rn_ready, 1);
    reset_n = 1'b1; settle();
    check_output("post_rst_enq_valid", enq_valid, 0);
    check_output("post_rst_rn_ready", rn_ready, 1);
    tick(); rn_valid = 1'b0; settle();
    check_output("first_enq_valid", enq_valid, 1);
    check_output("first_robidx", enq_robidx, 1);
    check_output("first_prd", enq_prd, 3);
    tick(); settle();
    check_output("first_drained", enq_valid, 0);

    // Dependent uop B reads prs1=5 just set by A.
    apply_stimulus(5'd2, 6'd0, 6'd0, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd3, 6'd5, 6'd0, 6'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); rn_valid = 1'b0; enq_ready = 1'b0; settle();
    check_output("dep_robidx", enq_robidx, 3);
    check_output("dep_src1_busy", enq_src1_state, 1);
    tick(); settle();
    check_output("dep_src1_still_busy", enq_src1_state, 1);
    writeback0_valid = 1'b1; writeback0_need_to_wb = 1'b1; writeback0_prd = 6'd5; settle();
    check_output("wb0_bypass", enq_src1_state, 0);
    tick(); writeback0_valid = 1'b0; settle();
    check_output("wb0_cleared", enq_src1_state, 0);
    enq_ready = 1'b1; tick(); settle();
    check_output("dep_drained", enq_valid, 0);

    // Writeback1 bypass on src2 at the handshake cycle.
    apply_stimulus(5'd4, 6'd0, 6'd0, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); rn_valid = 1'b0; tick();
    apply_stimulus(5'd5, 6'd0, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); rn_valid = 1'b0; settle();
    check_output("src2_busy", enq_src2_state, 1);
    writeback1_valid = 1'b1; writeback1_need_to_wb = 1'b1; writeback1_prd = 6'd9; settle();
    check_output("wb1_bypass", enq_src2_state, 0);
    tick(); writeback1_valid = 1'b0;
    apply_stimulus(5'd6, 6'd0, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); rn_valid = 1'b0; settle();
    check_output("busy9_cleared", enq_src2_state, 0);
    tick();

    // Stall fills the buffer; release delivers F, G, H in order.
    enq_ready = 1'b0;
    apply_stimulus(5'd7, 6'd1, 6'd2, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); settle();
    check_output("one_entry_rn_ready", rn_ready, 1);
    apply_stimulus(5'd8, 6'd1, 6'd2, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(5'd9, 6'd1, 6'd2, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check_output("full_rn_ready", rn_ready, 0);
    check_output("stall_robidx", enq_robidx, 7);
    tick(); tick(); settle();
    check_output("stall_robidx_stable", enq_robidx, 7);
    check_output("stall_payload_stable", enq_payload, payload_of(5'd7));
    check_output("stall_enq_valid", enq_valid, 1);
    enq_ready = 1'b1; settle();
    check_output("full_pop_rn_ready", rn_ready, 0);
    tick(); settle();
    check_output("order_g", enq_robidx, 8);
    check_output("after_pop_rn_ready", rn_ready, 1);
    tick(); rn_valid = 1'b0; settle();
    check_output("order_h", enq_robidx, 9);
    check_output("order_h_payload", enq_payload, payload_of(5'd9));
    tick(); settle();
    check_output("order_drained", enq_valid, 0);

    // Flush with two buffered uops; busy table left alone.
    enq_ready = 1'b0;
    apply_stimulus(5'd10, 6'd0, 6'd0, 6'd11, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd11, 6'd0, 6'd0, 6'd12, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd12, 6'd0, 6'd0, 6'd13, 1'b0, 1'b0, 1'b1, 1'b0);
    flush_valid = 1'b1; enq_ready = 1'b1; settle();
    check_output("flush_enq_valid", enq_valid, 0);
    check_output("flush_rn_ready", rn_ready, 0);
    tick(); flush_valid = 1'b0; rn_valid = 1'b0; settle();
    check_output("flush_empty", enq_valid, 0);
    apply_stimulus(5'd14, 6'd11, 6'd6, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); rn_valid = 1'b0; settle();
    check_output("post_flush_robidx", enq_robidx, 14);
    check_output("flush_no_set", enq_src1_state, 0);
    check_output("flush_keeps_busy6", enq_src2_state, 1);
    tick();

    // Set beats a same-cycle clear; dual writeback to one preg.
    apply_stimulus(5'd15, 6'd0, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); rn_valid = 1'b0;
    writeback0_valid = 1'b1; writeback0_need_to_wb = 1'b1; writeback0_prd = 6'd7;
    tick(); writeback0_valid = 1'b0;
    apply_stimulus(5'd16, 6'd7, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); rn_valid = 1'b0; enq_ready = 1'b0; settle();
    check_output("set_wins", enq_src1_state, 1);
    check_output("prs_zero", enq_src2_state, 0);
    writeback0_valid = 1'b1; writeback0_prd = 6'd7;
    writeback1_valid = 1'b1; writeback1_need_to_wb = 1'b1; writeback1_prd = 6'd7; settle();
    check_output("dual_wb_bypass", enq_src1_state, 0);
    tick(); writeback0_valid = 1'b0; writeback1_valid = 1'b0; settle();
    check_output("dual_wb_cleared", enq_src1_state, 0);
    enq_ready = 1'b1; tick();
    apply_stimulus(5'd17, 6'd6, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); rn_valid = 1'b0; settle();
    check_output("not_reg_ignores_busy", enq_src1_state, 0);
    check_output("robidx_flag", enq_robidx_flag, 1);
    tick();

    // Wakeup without need_to_wb must not clear busy[6].
    enq_ready = 1'b0;
    apply_stimulus(5'd18, 6'd6, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); rn_valid = 1'b0;
    writeback0_valid = 1'b1; writeback0_need_to_wb = 1'b0; writeback0_prd = 6'd6; settle();
    check_output("wb_no_need_no_bypass", enq_src1_state, 1);
    writeback0_valid = 1'b0;

    // Reset mid-operation discards the buffer and clears busy bits.
    reset_n = 1'b0; tick(); reset_n = 1'b1; settle();
    check_output("midrst_enq_valid", enq_valid, 0);
    apply_stimulus(5'd19, 6'd6, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); rn_valid = 1'b0; settle();
    check_output("midrst_robidx", enq_robidx, 19);
    check_output("midrst_busy_cleared", enq_src1_state, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Producer side of the integer issue-queue enqueue interface.
- Accepts renamed uops from rename through a 2-entry buffer and presents them in order to the issue queue.
- Owns the physical-register busy table. At the enqueue handshake it computes each uop's src1/src2 not-ready state, including same-cycle writeback bypass, because the issue queue does not wake entries enqueued in the wakeup cycle.

Parameters:
- PREG_W, 6, physical register index width (matches `PREG_RANGE).
- PREG_NUM, 64, number of physical registers (2**PREG_W).
- ROB_W, 5, ROB index width without flag (matches `ROB_SIZE_LOG).
- PAYLOAD_W, 192, opaque uop payload (pc, imm, lrs/lrd, type fields, ls_size, old_prd), passed through unmodified.

Ports:
- clock  in  1  sole clock
- reset_n  in  1  synchronous active-low reset
- rn_valid  in  1  rename uop valid
- rn_ready  out  1  buffer can accept
- rn_prs1, rn_prs2, rn_prd  in  PREG_W each  physical sources/dest
- rn_src1_is_reg, rn_src2_is_reg, rn_need_to_wb  in  1 each
- rn_robidx_flag  in  1;  rn_robidx  in  ROB_W
- rn_payload  in  PAYLOAD_W
- enq_valid  out  1  to issue queue
- enq_ready  in  1  issue queue slot free
- enq_prs1, enq_prs2, enq_prd  out  PREG_W
- enq_src1_is_reg, enq_src2_is_reg, enq_need_to_wb  out  1
- enq_robidx_flag  out  1;  enq_robidx  out  ROB_W
- enq_payload  out  PAYLOAD_W
- enq_src1_state, enq_src2_state  out  1  1 = operand busy (not ready)
- writeback0_valid, writeback0_need_to_wb  in  1;  writeback0_prd  in  PREG_W
- writeback1_valid, writeback1_need_to_wb  in  1;  writeback1_prd  in  PREG_W
- flush_valid  in  1  redirect; squash everything held here

Behaviour:
- Synchronous active-low reset (sampled on clock rising edge): buffer empty, enq_valid=0, rn_ready=1, all busy bits 0. Reset mid-operation discards buffered uops.
- Buffer: 2-entry in-order FIFO (1-bit ptrs + wrap flag).
  - rn_ready = ~full & ~flush_valid.
  - Write on rn_valid & rn_ready.
  - Full plus a simultaneous pop still refuses the push; rn_ready is not combinationally dependent on enq_ready.
- enq_valid = ~empty & ~flush_valid. enq_* fields are the head entry, directly from storage with no extra latency. A uop reaches the issue queue one cycle at the earliest after rn handshake.
- Pop on enq_valid & enq_ready. Fields stay stable while enq_valid=1 and enq_ready=0.
- Busy state, combinational at head:
  - srcN_state = srcN_is_reg & busy[prsN] & ~(wb0 hit on prsN) & ~(wb1 hit on prsN).
  - wbK hit = writebackK_valid & writebackK_need_to_wb & prd match.
  - prs=0 always reads not-busy.
- Busy table update each cycle:
  - clear busy[writebackK_prd] for each wakeup-qualified writeback.
  - set busy[enq_prd] on handshake when enq_need_to_wb and enq_prd≠0.
  - Set wins over a clear of the same index in the same cycle.
  - A set at cycle t is visible to the next head at t+1. Back-to-back dependent uops therefore see busy=1.
- Both writebacks may target the same preg: a single clear.
- Flush: cycle of flush_valid empties the buffer; no handshake on either side that cycle. The busy table is not modified by flush; stale busy bits on freed pregs are re-set on reallocation.
- Empty and not flushing: enq_valid=0. An empty buffer is never bypassed from rn to enq.

Decomposition:
- Shared package: PREG_W, ROB_W, PAYLOAD_W defaults and a uop struct typedef (prs1, prs2, prd, is_reg bits, need_to_wb, robidx_flag, robidx, payload).
- One sub-module: busy_table (PREG_NUM bits; two clear ports, one set port, two read ports with writeback bypass).

Test Plan:
- Reset with rn_valid=1 held -> enq_valid=0, rn_ready=1 the cycle after reset_n rises, then one uop emerges.
- Uop A (prd=5, need_to_wb=1) handshake at t; uop B prs1=5 is head at t+1 -> enq_src1_state=1. writeback0 prd=5 at t+3 -> B (if still stalled) shows src1_state=0 at t+3.
- Head prs2=9 with busy[9]=1 and writeback1 prd=9 same cycle as handshake -> enq_src2_state=0, and busy[9]=0 next cycle.
- enq_ready=0 for 4 cycles with rn_valid=1 -> buffer fills with 2 uops, rn_ready=0, enq fields stable. Release -> uops delivered in order, no loss or duplication.
- flush_valid with 2 buffered uops -> enq_valid=0 and rn_ready=0 that cycle, buffer empty next cycle, busy bits unchanged.
- Handshake setting prd=7 in the same cycle writeback0 prd=7 -> busy[7]=1 afterward. src_is_reg=0 with busy[prs]=1 -> state=0. prs=0 -> state=0.
